// File: rtl/tlc_pkg.sv
// Shared light codes, mode codes and FSM state encoding for the traffic phase controller.
// The FLASH state only exists when TLC_FLASH_EN is defined.
package tlc_pkg;

    localparam logic [1:0] LT_RED    = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_GREEN  = 2'b10;

    localparam logic [1:0] MODE_NORMAL = 2'b00;
    localparam logic [1:0] MODE_PED    = 2'b01;
    localparam logic [1:0] MODE_EMERG  = 2'b10;
    localparam logic [1:0] MODE_FLASH  = 2'b11;

    typedef enum logic [2:0] {
        ST_ALL_RED  = 3'd0,
        ST_GREEN    = 3'd1,
        ST_YELLOW   = 3'd2,
        ST_PED_WALK = 3'd3,
        ST_EMERG    = 3'd4
`ifdef TLC_FLASH_EN
        , ST_FLASH  = 3'd5
`endif
    } tlc_state_e;

endpackage

// File: rtl/tlc_phase_timer.sv
// Down-counter that times each controller state; done is high while the count reads zero.
module tlc_phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // Saturates at zero so states held by mode (walk hold) keep reporting expiry.
    always_ff @(posedge clk) begin
        if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// N-approach round-robin intersection controller with pedestrian walk and emergency preemption.
// Define TLC_FLASH_EN to add the flashing-yellow mode (mode=11); otherwise mode=11 behaves as normal.
module traffic_phase_controller
    import tlc_pkg::*;
#(
    parameter int NUM_PHASES = 4,
    parameter int CNT_W      = 8,
    parameter int GREEN_CYC  = 20,
    parameter int YELLOW_CYC = 4,
    parameter int ALLRED_CYC = 2,
    parameter int PED_CYC    = 10,
    parameter int FLASH_CYC  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      mode,
    input  logic                            ped_req,
    output logic [2*NUM_PHASES-1:0]         lights,
    output logic                            walk,
    output logic [$clog2(NUM_PHASES)-1:0]   phase,
    output logic                            ped_pending
);

    localparam int PH_W = $clog2(NUM_PHASES);
    localparam int CYC_MAX = (1 << CNT_W) - 1;

    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
    localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_CYC - 1);

    if (NUM_PHASES < 2 || NUM_PHASES > 8 ||
        GREEN_CYC < 1 || GREEN_CYC > CYC_MAX || YELLOW_CYC < 1 || YELLOW_CYC > CYC_MAX ||
        ALLRED_CYC < 1 || ALLRED_CYC > CYC_MAX || PED_CYC < 1 || PED_CYC > CYC_MAX ||
        FLASH_CYC < 1 || FLASH_CYC > CYC_MAX) begin : g_param_check
        $error("traffic_phase_controller: parameter out of range");
    end

    tlc_state_e              state, state_nxt;
    logic [PH_W-1:0]         phase_nxt;
    logic                    ped_nxt, walk_nxt;
    logic [2*NUM_PHASES-1:0] lights_nxt;
    logic                    fsm_load, tmr_load, tmr_done;
    logic [CNT_W-1:0]        fsm_val, tmr_val;
`ifdef TLC_FLASH_EN
    localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_CYC - 1);
    logic                    flash_on, flash_nxt;
`endif

    // Reset reloads the all-red clearance so the first green follows one full clearance.
    assign tmr_load = rst | fsm_load;
    assign tmr_val  = rst ? ALLRED_LD : fsm_val;

    tlc_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    function automatic logic [2*NUM_PHASES-1:0] approach_lights(input tlc_state_e st,
                                                                 input logic [PH_W-1:0] ph);
        logic [2*NUM_PHASES-1:0] l;
        l = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (PH_W'(i) == ph) begin
                if (st == ST_GREEN)       l[2*i +: 2] = LT_GREEN;
                else if (st == ST_YELLOW) l[2*i +: 2] = LT_YELLOW;
            end
        end
        return l;
    endfunction

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        ped_nxt   = ped_pending | ped_req;
        fsm_load  = 1'b0;
        fsm_val   = ALLRED_LD;
`ifdef TLC_FLASH_EN
        flash_nxt = flash_on;
`endif
        case (state)
            ST_ALL_RED: begin
                if (tmr_done) begin
                    fsm_load = 1'b1;
                    if (mode == MODE_EMERG) begin
                        state_nxt = ST_EMERG;
                    end
`ifdef TLC_FLASH_EN
                    else if (mode == MODE_FLASH) begin
                        state_nxt = ST_FLASH;
                        fsm_val   = FLASH_LD;
                        flash_nxt = 1'b1;
                    end
`endif
                    else if (ped_pending || mode == MODE_PED) begin
                        // A button press on this same edge is served by this walk.
                        state_nxt = ST_PED_WALK;
                        fsm_val   = PED_LD;
                        ped_nxt   = 1'b0;
                    end else begin
                        state_nxt = ST_GREEN;
                        fsm_val   = GREEN_LD;
                    end
                end
            end
            ST_GREEN: begin
                if (tmr_done || mode == MODE_EMERG) begin
                    state_nxt = ST_YELLOW;
                    fsm_load  = 1'b1;
                    fsm_val   = YELLOW_LD;
                end
            end
            ST_YELLOW: begin
                if (tmr_done) begin
                    state_nxt = ST_ALL_RED;
                    fsm_load  = 1'b1;
                    phase_nxt = (phase == PH_W'(NUM_PHASES - 1)) ? '0 : phase + 1'b1;
                end
            end
            ST_PED_WALK: begin
                if (mode == MODE_EMERG || (tmr_done && mode != MODE_PED)) begin
                    state_nxt = ST_ALL_RED;
                    fsm_load  = 1'b1;
                end
            end
            ST_EMERG: begin
                if (mode != MODE_EMERG) begin
                    state_nxt = ST_ALL_RED;
                    fsm_load  = 1'b1;
                end
            end
`ifdef TLC_FLASH_EN
            ST_FLASH: begin
                if (mode != MODE_FLASH) begin
                    state_nxt = ST_ALL_RED;
                    fsm_load  = 1'b1;
                end else if (tmr_done) begin
                    fsm_load  = 1'b1;
                    fsm_val   = FLASH_LD;
                    flash_nxt = ~flash_on;
                end
            end
`endif
            default: begin
                state_nxt = ST_ALL_RED;
                fsm_load  = 1'b1;
            end
        endcase

        walk_nxt = (state_nxt == ST_PED_WALK);
`ifdef TLC_FLASH_EN
        if (state_nxt == ST_FLASH) begin
            lights_nxt = flash_nxt ? {NUM_PHASES{LT_YELLOW}} : '0;
        end else begin
            lights_nxt = approach_lights(state_nxt, phase_nxt);
        end
`else
        lights_nxt = approach_lights(state_nxt, phase_nxt);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ALL_RED;
            phase       <= '0;
            ped_pending <= 1'b0;
            lights      <= '0;
            walk        <= 1'b0;
`ifdef TLC_FLASH_EN
            flash_on    <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            phase       <= phase_nxt;
            ped_pending <= ped_nxt;
            lights      <= lights_nxt;
            walk        <= walk_nxt;
`ifdef TLC_FLASH_EN
            flash_on    <= flash_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Directed bench for traffic_phase_controller with 3 approaches and short state timings.
// Covers normal rotation, pedestrian service/hold, preemption, mode 11 and mid-yellow reset.
module tb_traffic_phase_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] mode;
    logic       ped_req;
    logic [5:0] lights;
    logic       walk;
    logic [1:0] phase;
    logic       ped_pending;

    int checks = 0;
    int errors = 0;
    logic inv_en = 1'b0;

    localparam logic [5:0] R    = 6'b000000;
    localparam logic [5:0] G0   = 6'b000010;
    localparam logic [5:0] Y0   = 6'b000001;
    localparam logic [5:0] G1   = 6'b001000;
    localparam logic [5:0] Y1   = 6'b000100;
    localparam logic [5:0] G2   = 6'b100000;
    localparam logic [5:0] Y2   = 6'b010000;
    localparam logic [5:0] YALL = 6'b010101;

    traffic_phase_controller #(
        .NUM_PHASES (3),
        .CNT_W      (8),
        .GREEN_CYC  (4),
        .YELLOW_CYC (2),
        .ALLRED_CYC (1),
        .PED_CYC    (3),
        .FLASH_CYC  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .ped_req     (ped_req),
        .lights      (lights),
        .walk        (walk),
        .phase       (phase),
        .ped_pending (ped_pending)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Drive mode for n edges (ped_req only on the first) and check all outputs after each edge.
    task automatic applyStimulus(input string tag, input int n, input logic [1:0] m, input logic p,
                                 input logic [5:0] exp_l, input logic exp_w,
                                 input logic [1:0] exp_ph, input logic exp_pp);
        for (int k = 0; k < n; k++) begin
            mode    = m;
            ped_req = (k == 0) ? p : 1'b0;
            @(posedge clk);
            #1;
            ped_req = 1'b0;
            checkOutput($sformatf("%s[%0d].lights", tag, k), 32'(lights), 32'(exp_l));
            checkOutput($sformatf("%s[%0d].walk", tag, k), 32'(walk), 32'(exp_w));
            checkOutput($sformatf("%s[%0d].phase", tag, k), 32'(phase), 32'(exp_ph));
            checkOutput($sformatf("%s[%0d].ped_pending", tag, k), 32'(ped_pending), 32'(exp_pp));
        end
    endtask

    always @(negedge clk) begin
        if (inv_en) begin
            int nonred;
            nonred = 0;
            for (int i = 0; i < 3; i++) if (lights[2*i +: 2] != 2'b00) nonred++;
            checkOutput("inv_one_active", 32'(nonred <= 1), 32'd1);
            checkOutput("inv_walk_all_red", 32'(walk && (lights != 6'b0)), 32'd0);
        end
    end

    initial begin
        rst     = 1'b1;
        mode    = 2'b00;
        ped_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.lights", 32'(lights), 32'(R));
        checkOutput("reset.walk", 32'(walk), 32'd0);
        checkOutput("reset.phase", 32'(phase), 32'd0);
        checkOutput("reset.ped_pending", 32'(ped_pending), 32'd0);
        inv_en = 1'b1;
        rst    = 1'b0;

        // Normal rotation: 4 green, 2 yellow, 1 all-red per approach.
        applyStimulus("a0_green",  4, 2'b00, 1'b0, G0, 1'b0, 2'd0, 1'b0);
        applyStimulus("a0_yellow", 2, 2'b00, 1'b0, Y0, 1'b0, 2'd0, 1'b0);
        applyStimulus("a0_red",    1, 2'b00, 1'b0, R,  1'b0, 2'd1, 1'b0);
        applyStimulus("a1_green",  4, 2'b00, 1'b0, G1, 1'b0, 2'd1, 1'b0);
        applyStimulus("a1_yellow", 2, 2'b00, 1'b0, Y1, 1'b0, 2'd1, 1'b0);
        applyStimulus("a1_red",    1, 2'b00, 1'b0, R,  1'b0, 2'd2, 1'b0);
        applyStimulus("a2_green",  4, 2'b00, 1'b0, G2, 1'b0, 2'd2, 1'b0);
        applyStimulus("a2_yellow", 2, 2'b00, 1'b0, Y2, 1'b0, 2'd2, 1'b0);
        applyStimulus("a2_red",    1, 2'b00, 1'b0, R,  1'b0, 2'd0, 1'b0);

        // Pedestrian request during approach 0 green.
        applyStimulus("p_green",    1, 2'b00, 1'b0, G0, 1'b0, 2'd0, 1'b0);
        applyStimulus("p_req",      1, 2'b00, 1'b1, G0, 1'b0, 2'd0, 1'b1);
        applyStimulus("p_green2",   2, 2'b00, 1'b0, G0, 1'b0, 2'd0, 1'b1);
        applyStimulus("p_yellow",   2, 2'b00, 1'b0, Y0, 1'b0, 2'd0, 1'b1);
        applyStimulus("p_red",      1, 2'b00, 1'b0, R,  1'b0, 2'd1, 1'b1);
        applyStimulus("p_walk",     3, 2'b00, 1'b0, R,  1'b1, 2'd1, 1'b0);
        applyStimulus("p_clear",    1, 2'b00, 1'b0, R,  1'b0, 2'd1, 1'b0);
        applyStimulus("p_a1_green", 4, 2'b00, 1'b0, G1, 1'b0, 2'd1, 1'b0);

        // Pedestrian hold mode.
        applyStimulus("h_yellow",   2, 2'b01, 1'b0, Y1, 1'b0, 2'd1, 1'b0);
        applyStimulus("h_red",      1, 2'b01, 1'b0, R,  1'b0, 2'd2, 1'b0);
        applyStimulus("h_walk",    10, 2'b01, 1'b0, R,  1'b1, 2'd2, 1'b0);
        applyStimulus("h_release",  1, 2'b00, 1'b0, R,  1'b0, 2'd2, 1'b0);
        applyStimulus("h_a2_green", 2, 2'b00, 1'b0, G2, 1'b0, 2'd2, 1'b0);

        // Emergency preemption at green cycle 2.
        applyStimulus("e_yellow",   2, 2'b10, 1'b0, Y2, 1'b0, 2'd2, 1'b0);
        applyStimulus("e_red",      1, 2'b10, 1'b0, R,  1'b0, 2'd0, 1'b0);
        applyStimulus("e_hold",     3, 2'b10, 1'b0, R,  1'b0, 2'd0, 1'b0);
        applyStimulus("e_release",  1, 2'b00, 1'b0, R,  1'b0, 2'd0, 1'b0);
        applyStimulus("e_a0_green", 4, 2'b00, 1'b0, G0, 1'b0, 2'd0, 1'b0);

        // Button pressed again on the very edge that starts the walk is absorbed.
        applyStimulus("x_yel_req",  1, 2'b00, 1'b1, Y0, 1'b0, 2'd0, 1'b1);
        applyStimulus("x_yellow",   1, 2'b00, 1'b0, Y0, 1'b0, 2'd0, 1'b1);
        applyStimulus("x_red",      1, 2'b00, 1'b0, R,  1'b0, 2'd1, 1'b1);
        applyStimulus("x_walk_req", 1, 2'b00, 1'b1, R,  1'b1, 2'd1, 1'b0);
        applyStimulus("x_walk",     2, 2'b00, 1'b0, R,  1'b1, 2'd1, 1'b0);
        applyStimulus("x_clear",    1, 2'b00, 1'b0, R,  1'b0, 2'd1, 1'b0);
        applyStimulus("x_a1_green", 1, 2'b00, 1'b0, G1, 1'b0, 2'd1, 1'b0);

        // Mode 11: flashing when enabled, otherwise identical to normal.
        applyStimulus("f_green",    3, 2'b11, 1'b0, G1, 1'b0, 2'd1, 1'b0);
        applyStimulus("f_yellow",   2, 2'b11, 1'b0, Y1, 1'b0, 2'd1, 1'b0);
        applyStimulus("f_red",      1, 2'b11, 1'b0, R,  1'b0, 2'd2, 1'b0);
`ifdef TLC_FLASH_EN
        applyStimulus("fl_on",      8, 2'b11, 1'b0, YALL, 1'b0, 2'd2, 1'b0);
        applyStimulus("fl_off",     8, 2'b11, 1'b0, R,    1'b0, 2'd2, 1'b0);
        applyStimulus("fl_on2",     1, 2'b11, 1'b0, YALL, 1'b0, 2'd2, 1'b0);
        applyStimulus("fl_exit",    1, 2'b00, 1'b0, R,    1'b0, 2'd2, 1'b0);
        applyStimulus("fl_green",   4, 2'b00, 1'b0, G2,   1'b0, 2'd2, 1'b0);
        applyStimulus("r_yellow",   1, 2'b00, 1'b1, Y2,   1'b0, 2'd2, 1'b1);
`else
        applyStimulus("n_a2_green", 4, 2'b11, 1'b0, G2, 1'b0, 2'd2, 1'b0);
        applyStimulus("n_a2_yel",   2, 2'b11, 1'b0, Y2, 1'b0, 2'd2, 1'b0);
        applyStimulus("n_a2_red",   1, 2'b11, 1'b0, R,  1'b0, 2'd0, 1'b0);
        applyStimulus("n_a0_green", 4, 2'b00, 1'b0, G0, 1'b0, 2'd0, 1'b0);
        applyStimulus("n_a0_yel",   2, 2'b00, 1'b0, Y0, 1'b0, 2'd0, 1'b0);
        applyStimulus("n_a0_red",   1, 2'b00, 1'b0, R,  1'b0, 2'd1, 1'b0);
        applyStimulus("n_a1_green", 4, 2'b00, 1'b0, G1, 1'b0, 2'd1, 1'b0);
        applyStimulus("r_yellow",   1, 2'b00, 1'b1, Y1, 1'b0, 2'd1, 1'b1);
`endif

        // Reset in the middle of yellow wins over the pending transition.
        rst  = 1'b1;
        mode = 2'b00;
        @(posedge clk);
        #1;
        checkOutput("midrst.lights", 32'(lights), 32'(R));
        checkOutput("midrst.walk", 32'(walk), 32'd0);
        checkOutput("midrst.phase", 32'(phase), 32'd0);
        checkOutput("midrst.ped_pending", 32'(ped_pending), 32'd0);
        rst = 1'b0;
        applyStimulus("post_rst_green", 1, 2'b00, 1'b0, G0, 1'b0, 2'd0, 1'b0);

        inv_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
